// File: rtl/inst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_pkg
// Description : Shared bus definitions for the fetch -> queue -> decode path.
//               Holds the queue geometry, the fetch-to-queue and
//               queue-to-decode bus widths, the entry layout and a pointer
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_queue_pkg;

  // Queue geometry
  localparam int IqDepth      = 4;
  localparam int IqEntryWidth = 65;

  // Bus widths on either side of the queue; both carry one queue entry.
  localparam int FsToIqBusWd  = IqEntryWidth;
  localparam int IqToIdBusWd  = IqEntryWidth;

  // Entry field positions
  localparam int IqAdefBit    = 64;
  localparam int IqPcMsb      = 63;
  localparam int IqPcLsb      = 32;

  // Entry layout: {ADEF exception flag, pc, instruction}
  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  // Read/write pointers carry one extra wrap bit above the address bits.
  function automatic int iq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_if
// Description : Handshake bundle around the instruction queue: the fetch-side
//               offer, the decode-side head presentation, the flush and the
//               occupancy count.
//   master : drives flush, fs_to_iq_valid, fs_to_iq_bus, id_allowin
//   slave  : the queue; drives iq_allowin, iq_to_id_valid, iq_to_id_bus,
//            iq_count
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int ENTRY_W = IqEntryWidth,
  parameter int DEPTH   = IqDepth
);

  logic                       flush;
  logic                       fs_to_iq_valid;
  logic [ENTRY_W-1:0]         fs_to_iq_bus;
  logic                       iq_allowin;
  logic                       iq_to_id_valid;
  logic [ENTRY_W-1:0]         iq_to_id_bus;
  logic                       id_allowin;
  logic [$clog2(DEPTH):0]     iq_count;

  modport master (
    output flush,
    output fs_to_iq_valid,
    output fs_to_iq_bus,
    output id_allowin,
    input  iq_allowin,
    input  iq_to_id_valid,
    input  iq_to_id_bus,
    input  iq_count
  );

  modport slave (
    input  flush,
    input  fs_to_iq_valid,
    input  fs_to_iq_bus,
    input  id_allowin,
    output iq_allowin,
    output iq_to_id_valid,
    output iq_to_id_bus,
    output iq_count
  );

endinterface
`default_nettype wire

// File: rtl/inst_queue_ram.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_ram
// Description : DEPTH x ENTRY_W register array, one synchronous write port
//               and one asynchronous read port. Contents are not reset.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue_ram #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 65
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ENTRY_W-1:0]       rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Instruction queue between fetch and decode. Buffers
//               {ADEF, pc, inst} entries in a DEPTH-entry FIFO, presents the
//               oldest to decode under valid/allowin, and discards everything
//               on flush.
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (clears pointers only)
//   bus_if  slave modport of inst_queue_if (flush, fetch offer, decode head,
//           occupancy)
// Options     : IQ_BYPASS_EN - when defined, an entry offered to an empty
//               queue that decode accepts in the same cycle is forwarded
//               combinationally and never written.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = IqDepth,
  parameter int ENTRY_W = IqEntryWidth
) (
  input  logic        clk,
  input  logic        rst,
  inst_queue_if.slave bus_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = iq_ptr_w(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("inst_queue: DEPTH must be a power of two and at least 2");
    end
    if (IqToIdBusWd != IqEntryWidth) begin : g_bad_bus_w
      $error("inst_queue: decode bus width must equal the entry width");
    end
  endgenerate

  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic               w_empty;
  logic               w_full;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_rd_data;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign w_empty = (rd_ptr_q == wr_ptr_q);
  assign w_full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                   (rd_ptr_q[AW] != wr_ptr_q[AW]);

`ifdef IQ_BYPASS_EN
  // Reset is treated like a flush, so it also suppresses forwarding.
  assign w_bypass = w_empty & bus_if.fs_to_iq_valid & bus_if.id_allowin &
                    ~bus_if.flush & ~rst;
`else
  assign w_bypass = 1'b0;
`endif

  // A forwarded entry is consumed directly and never occupies a slot.
  assign w_push = bus_if.fs_to_iq_valid & ~w_full & ~w_bypass &
                  ~bus_if.flush & ~rst;
  assign w_pop  = ~w_empty & bus_if.id_allowin;

  // Not pop-aware: keeps id_allowin off the combinational path to fetch.
  assign bus_if.iq_allowin     = ~w_full;
  assign bus_if.iq_to_id_valid = ~w_empty | w_bypass;
  assign bus_if.iq_to_id_bus   = w_bypass ? bus_if.fs_to_iq_bus : w_rd_data;
  assign bus_if.iq_count       = wr_ptr_q - rd_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus_if.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  inst_queue_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus_if.fs_to_iq_bus),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (w_rd_data)
  );

endmodule
`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage. Buffers fetched {exception flag, pc, instruction} entries in a small FIFO so fetch can continue while decode stalls. Presents the oldest entry to decode under a valid/allowin handshake. Discards all entries on a pipeline flush from a branch or exception.

## Interface
- `DEPTH`, 4, number of entries; must be a power of two and at least 2.
- `ENTRY_W`, 65, entry width: bit 64 = ADEF exception flag, bits 63:32 = pc, bits 31:0 = instruction.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  pipeline flush from the exception/branch redirect path.
- `fs_to_iq_valid`  in  1  fetch is presenting an entry.
- `fs_to_iq_bus`  in  ENTRY_W  fetched entry.
- `iq_allowin`  out  1  queue accepts an entry this cycle.
- `iq_to_id_valid`  out  1  head entry is valid for decode.
- `iq_to_id_bus`  out  ENTRY_W  head entry; feeds the decode bus.
- `id_allowin`  in  1  decode accepts the head this cycle.
- `iq_count`  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH-entry register array. Read pointer and write pointer are each log2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- push = `fs_to_iq_valid & iq_allowin`. Writes the entry at the write pointer, then increments the write pointer.
- pop = `iq_to_id_valid & id_allowin`. Increments the read pointer.
- `iq_allowin` = !full. It is not pop-aware, so there is no combinational path from `id_allowin` to `iq_allowin`.
- `iq_to_id_valid` = !empty. `iq_to_id_bus` = entry at the read pointer.
- Push and pop in the same cycle: both pointers advance and `iq_count` is unchanged. This is legal at any occupancy where push is permitted.
- Pointers wrap naturally modulo 2·DEPTH. There is no special-case logic at the wrap point.
- `flush`: both pointers clear to 0 at the next edge. It overrides any push or pop in the same cycle, so the entry offered that cycle is dropped.
- `iq_count` = write pointer − read pointer, computed modulo 2·DEPTH. Range is 0..DEPTH.
- The array contents are not reset. Only the pointers are reset.

## Timing
- Reset: both pointers are 0. As a result `iq_to_id_valid`=0, `iq_allowin`=1, `iq_count`=0, and `iq_to_id_bus` is don't-care.
- A reset asserted mid-operation behaves exactly like flush plus the reset values above. It is effective at the next edge.
- Latency without bypass: an entry pushed at edge N is visible on `iq_to_id_valid`/`iq_to_id_bus` after edge N, i.e. in cycle N+1.
- Throughput is one push and one pop per cycle sustained.
- `iq_allowin` deasserts in the cycle after the queue fills. It reasserts in the cycle after the first pop from full.
- Flush at edge N: `iq_to_id_valid`=0 in cycle N+1, and a new push is accepted in cycle N+1.

## Configuration
- Macro `IQ_BYPASS_EN`.
- Defined: when the queue is empty, `fs_to_iq_valid`=1, `id_allowin`=1 and `flush`=0:
  - the incoming entry drives `iq_to_id_bus` combinationally;
  - `iq_to_id_valid`=1 in the same cycle;
  - the entry is consumed without being written, and the pointers do not move.
  - Latency is 0 cycles in this case.
- Undefined: no bypass, and the latency is always 1 cycle.
- Bypass never applies during a flush.

## Structure
- `IqEntryWidth` and `IqDepth` live in the shared bus-definition header, alongside the fetch-to-queue and queue-to-decode bus-width macros.
- The decode bus-width macro must equal `IqEntryWidth`.
- One sub-module, `inst_queue_ram`: the DEPTH×ENTRY_W register array with one write port and one asynchronous read port.
- Pointers, flags and the handshake stay in `inst_queue`.

## Test plan
- Reset then idle:
  - `iq_allowin`=1, `iq_to_id_valid`=0, `iq_count`=0.
- Fill with `id_allowin`=0, pushing pc 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c:
  - `iq_count`=4 and `iq_allowin`=0;
  - a fifth offer is not accepted;
  - the head is pc 0x1c000000.
- Drain in order:
  - pops return pc 0x…00, 0x…04, 0x…08, 0x…0c with inst and ADEF intact;
  - then `iq_to_id_valid`=0.
- Sustained push/pop at count 2 for 20 cycles, crossing the pointer wrap:
  - `iq_count` stays 2;
  - output order matches input order exactly.
- Flush at count 3 with a simultaneous push and pop:
  - next cycle `iq_count`=0 and `iq_to_id_valid`=0;
  - the pushed entry never appears at the output.
- With `IQ_BYPASS_EN`, empty queue, `fs_to_iq_valid`=1 and `id_allowin`=1 (pc 0x1c000010):
  - same cycle, `iq_to_id_valid`=1 and bus pc=0x1c000010;
  - `iq_count` remains 0.
  - Without the macro, the same entry appears one cycle later.
